// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parity modes and frame sizing for the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + (parity != PAR_NONE ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO; the extra pointer MSB separates full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-fed UART transmitter with configurable data width, parity and stop bits
module uart_tx_cfg import uart_pkg::*; #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 start_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic                 tx
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  if (CLOCKS_PER_BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end
  uart_state_t state;
  logic [CW-1:0] baud;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] shreg, fifo_dout;
  logic par_bit, frame_end, full, empty, pop, baud_end, last_stop, line_bit;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(start_i), .pop(pop),
    .din(data_i), .dout(fifo_dout), .full(full), .empty(empty)
  );
  assign ready_o   = !full;
  assign baud_end  = baud == CW'(CLOCKS_PER_BAUD - 1);
  assign last_stop = state == STOP && baud_end && idx == 4'(STOP_BITS - 1);
  assign pop       = !empty && (state == IDLE || last_stop);
  assign line_bit  = state == START ? 1'b0 :
                     state == DATA ? shreg[0] :
                     state == uart_pkg::PARITY ? par_bit : 1'b1;
  // tx trails the FSM by one register stage, so done_o is delayed to match the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      frame_end  <= 1'b0;
      tx         <= 1'b1;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      tx         <= line_bit;
      frame_end  <= last_stop;
      done_o     <= frame_end;
      overflow_o <= start_i && full;
      busy_o     <= state != IDLE || !empty || frame_end;
      baud       <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
      if (pop) begin
        shreg   <= fifo_dout;
        par_bit <= (^fifo_dout) ^ (PARITY == PAR_ODD);
        idx     <= '0;
        state   <= START;
      end else if (state != IDLE && baud_end) begin
        case (state)
          START: begin
            idx   <= '0;
            state <= DATA;
          end
          DATA: begin
            shreg <= shreg >> 1;
            idx   <= idx == 4'(DATA_BITS - 1) ? '0 : idx + 1'b1;
            if (idx == 4'(DATA_BITS - 1)) state <= PARITY != PAR_NONE ? uart_pkg::PARITY : STOP;
          end
          uart_pkg::PARITY: begin
            idx   <= '0;
            state <= STOP;
          end
          STOP: begin
            idx <= idx + 1'b1;
            if (idx == 4'(STOP_BITS - 1)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three configurations (8N1, 7E2, 7O2) against a frame-level reference model
module tb_uart_tx_cfg;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [8:0] data = '0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask
  // whole frame as a bit vector, index 0 = start bit, unused tail bits are 1
  function automatic logic [15:0] mk(input int w, input int db, input int par);
    logic [15:0] f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) f[1 + i] = w[i];
    if (par != 0) f[1 + db] = par == 1 ? ($countones(w) % 2 == 0) : ($countones(w) % 2 == 1);
    return f;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int DB  = g == 0 ? 8 : 7;
    localparam int PAR = g == 0 ? 0 : (g == 1 ? 2 : 1);
    localparam int SB  = g == 0 ? 1 : 2;
    localparam int LEN = 1 + DB + (PAR != 0 ? 1 : 0) + SB;
    logic tx_w, ready_w, busy_w, done_w, ovf_w;
    uart_tx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB),
                  .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_i(data[DB-1:0]), .start_i(start), .ready_o(ready_w),
      .busy_o(busy_w), .done_o(done_w), .overflow_o(ovf_w), .tx(tx_w)
    );
    int q[$];
    logic act = 1'b0, fend = 1'b0;
    int pos = 0;
    logic [15:0] frame = '1;
    logic e_tx = 1'b1, e_done = 1'b0, e_busy = 1'b0, e_ovf = 1'b0;
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        act = 1'b0; fend = 1'b0; pos = 0;
        e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
      end else begin
        e_tx   = act ? frame[pos / CPB] : 1'b1;
        e_done = fend;
        e_busy = act || q.size() != 0 || fend;
        e_ovf  = start && q.size() == DEPTH;
        fend   = act && pos == LEN * CPB - 1;
        if (act && !fend) pos++;
        else if (q.size() != 0) begin
          frame = mk(q.pop_front(), DB, PAR);
          act = 1'b1;
          pos = 0;
        end else act = 1'b0;
        if (start && !e_ovf) q.push_back(int'(data[DB-1:0]));
      end
    end
    always @(negedge clk) begin
      chk($sformatf("tx[%0d]", g), tx_w, e_tx);
      chk($sformatf("done[%0d]", g), done_w, e_done);
      chk($sformatf("busy[%0d]", g), busy_w, e_busy);
      chk($sformatf("overflow[%0d]", g), ovf_w, e_ovf);
      chk($sformatf("ready[%0d]", g), ready_w, q.size() < DEPTH);
    end
  end
  task automatic push(input logic [8:0] d);
    start = 1'b1;
    data = d;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((g_cfg[0].busy_w || g_cfg[1].busy_w || g_cfg[2].busy_w) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 1000, 1'b1);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    logic [9:0] p0 = 10'b1101001010;
    logic [10:0] p1 = 11'b11100001110;
    logic [10:0] p2 = 11'b11000001110;
    int t0, t1;
    logic stayed;
    repeat (2) @(negedge clk);
    chk("reset_tx", g_cfg[0].tx_w, 1'b1);
    chk("reset_ready", g_cfg[0].ready_w, 1'b1);
    chk("reset_busy", g_cfg[0].busy_w, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    push(9'h0A5);
    @(negedge clk);
    chk("latency_k1", g_cfg[0].tx_w, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("frame_a5", g_cfg[0].tx_w, p0[i / 4]);
    end
    @(negedge clk);
    chk("done_a5", g_cfg[0].done_w, 1'b1);
    wait_idle();
    push(9'h007);
    @(negedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk("frame_7e2", g_cfg[1].tx_w, p1[i / 4]);
      chk("frame_7o2", g_cfg[2].tx_w, p2[i / 4]);
    end
    wait_idle();
    start = 1'b1; data = 9'h0FF;
    @(negedge clk);
    data = 9'h081;
    @(negedge clk);
    start = 1'b0;
    t0 = -1; t1 = -1;
    for (int n = 0; n < 200 && t1 < 0; n++) begin
      @(negedge clk);
      if (g_cfg[0].done_w) begin
        if (t0 < 0) t0 = n;
        else t1 = n;
      end
    end
    chk("b2b_done_gap", t1 - t0 == 40, 1'b1);
    wait_idle();
    push(9'h155);
    repeat (3) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 9'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    start = 1'b1; data = 9'h03C;
    @(negedge clk);
    data = 9'h111;
    @(negedge clk);
    data = 9'h0E7;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx", g_cfg[0].tx_w, 1'b1);
    chk("rst_mid_busy", g_cfg[0].busy_w, 1'b0);
    chk("rst_mid_ready", g_cfg[0].ready_w, 1'b1);
    chk("rst_mid_done", g_cfg[0].done_w, 1'b0);
    stayed = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!g_cfg[0].tx_w || g_cfg[0].done_w) stayed = 1'b0;
    end
    chk("rst_mid_silent", stayed, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 3) == 0;
      data = 9'($urandom);
      rst = $urandom_range(0, 999) == 0;
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
